// File: rtl/conv2_sched.sv
// conv2_sched: weight-load and credit-throttled raster window scheduler for a KxK stride-1 convolution pass.
module conv2_sched #(
  parameter int IMG_H   = 8,
  parameter int IMG_W   = 8,
  parameter int K       = 3,
  parameter int N_IN    = 16,
  parameter int OUT_CH  = 32,
  parameter int CREDITS = 4,
  localparam int NUM_W  = OUT_CH * N_IN * K * K,
  localparam int AW     = $clog2(NUM_W),
  localparam int RW     = $clog2(IMG_H),
  localparam int CW     = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          skip_wload,
  input  logic          abort,
  output logic          wld_valid,
  output logic [AW-1:0] wld_addr,
  input  logic          wld_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          window_valid,
  input  logic          res_consumed,
  output logic          busy,
  output logic          done
);
  localparam int CRW = $clog2(CREDITS + 1);
  localparam logic [AW-1:0]  A_LAST = AW'(NUM_W - 1);
  localparam logic [RW-1:0]  R_LAST = RW'(IMG_H - K);
  localparam logic [CW-1:0]  C_LAST = CW'(IMG_W - K);
  localparam logic [CRW-1:0] C_FULL = CRW'(CREDITS);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t         state;
  logic [CRW-1:0] credits, cr_n;
  logic [CRW:0]   sum;
  logic           hs, last_win;
  // window_valid is the registered issue strobe, so it doubles as the credit debit
  always_comb begin
    hs       = wld_valid && wld_ready;
    last_win = win_row == R_LAST && win_col == C_LAST;
    sum      = {1'b0, credits} + {{CRW{1'b0}}, res_consumed} - {{CRW{1'b0}}, window_valid};
    cr_n     = sum > {1'b0, C_FULL} ? C_FULL : sum[CRW-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      wld_valid    <= 1'b0;
      wld_addr     <= '0;
      window_valid <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
      credits      <= C_FULL;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state        <= IDLE;
        busy         <= 1'b0;
        wld_valid    <= 1'b0;
        wld_addr     <= '0;
        window_valid <= 1'b0;
        win_row      <= '0;
        win_col      <= '0;
        credits      <= C_FULL;
      end else begin
        case (state)
          IDLE: if (start) begin
            state        <= skip_wload ? RUN : LOAD;
            busy         <= 1'b1;
            wld_valid    <= !skip_wload;
            window_valid <= skip_wload;
            credits      <= C_FULL;
          end
          LOAD: if (hs) begin
            if (wld_addr == A_LAST) begin
              state        <= RUN;
              wld_valid    <= 1'b0;
              wld_addr     <= '0;
              window_valid <= 1'b1;
              credits      <= C_FULL;
            end else wld_addr <= wld_addr + AW'(1);
          end
          RUN: begin
            credits      <= cr_n;
            window_valid <= !(window_valid && last_win) && cr_n != '0;
            if (window_valid) begin
              if (last_win) begin
                state   <= DRAIN;
                win_row <= '0;
                win_col <= '0;
              end else if (win_col == C_LAST) begin
                win_col <= '0;
                win_row <= win_row + RW'(1);
              end else win_col <= win_col + CW'(1);
            end
          end
          DRAIN: begin
            credits <= cr_n;
            if (credits == C_FULL) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_conv2_sched.sv
// tb_conv2_sched: randomized bench against a window-index/credit-count reference model.
module tb_conv2_sched;
  localparam int H = 5, W = 5, KK = 3, NI = 1, OC = 2, CR = 2;
  localparam int NW = OC * NI * KK * KK;
  localparam int OH = H - KK + 1, OW = W - KK + 1, TOT = OH * OW;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, skip_wload = 1'b0, abort = 1'b0;
  logic wld_ready = 1'b0, res_consumed = 1'b0;
  logic wld_valid, window_valid, busy, done;
  logic [$clog2(NW)-1:0] wld_addr;
  logic [$clog2(H)-1:0]  win_row;
  logic [$clog2(W)-1:0]  win_col;
  int checks = 0, failures = 0;
  int ph, addr, idx, avail, nwin, ndone, nhs;
  conv2_sched #(.IMG_H(H), .IMG_W(W), .K(KK), .N_IN(NI), .OUT_CH(OC), .CREDITS(CR)) dut (
    .clk(clk), .rst(rst), .start(start), .skip_wload(skip_wload), .abort(abort),
    .wld_valid(wld_valid), .wld_addr(wld_addr), .wld_ready(wld_ready),
    .win_row(win_row), .win_col(win_col), .window_valid(window_valid),
    .res_consumed(res_consumed), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // ph: 0 idle, 1 load, 2 run, 3 drain, 4 done; idx counts windows issued so far
  function automatic void mdl_reset();
    ph = 0; addr = 0; idx = 0; avail = CR;
  endfunction
  function automatic int cap(input int v);
    return v > CR ? CR : v;
  endfunction
  function automatic void mdl_step();
    int iss;
    if (abort && ph != 0) begin
      ph = 0; avail = CR;
    end else begin
      case (ph)
        0: if (start) begin ph = skip_wload ? 2 : 1; addr = 0; idx = 0; avail = CR; end
        1: if (wld_ready) begin
          if (addr == NW - 1) begin ph = 2; idx = 0; avail = CR; end
          else addr++;
        end
        2: begin
          iss = avail > 0 ? 1 : 0;
          idx += iss;
          avail = cap(avail - iss + int'(res_consumed));
          if (idx == TOT) ph = 3;
        end
        3: if (avail == CR) ph = 4; else avail = cap(avail + int'(res_consumed));
        default: ph = 0;
      endcase
    end
  endfunction
  task automatic check_outs();
    chk("busy", busy, ph != 0);
    chk("done", done, ph == 4);
    chk("wld_valid", wld_valid, ph == 1);
    chk("wld_addr", wld_addr, ph == 1 ? addr : 0);
    chk("window_valid", window_valid, ph == 2 && avail > 0);
    chk("win_row", win_row, ph == 2 ? idx / OW : 0);
    chk("win_col", win_col, ph == 2 ? idx % OW : 0);
  endtask
  task automatic tick();
    if (wld_valid && wld_ready) nhs++;
    mdl_step();
    @(negedge clk);
    check_outs();
    if (window_valid) nwin++;
    if (done) ndone++;
  endtask
  task automatic begin_pass(input logic skip);
    nwin = 0; ndone = 0; nhs = 0;
    skip_wload = skip; start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic run_to_idle(input string tag, input int lim);
    int n = 0;
    while (ph != 0 && n < lim) begin
      tick();
      n++;
    end
    chk(tag, ph, 0);
  endtask
  initial begin
    mdl_reset();
    repeat (2) @(negedge clk);
    check_outs();
    rst = 1'b0;
    tick();
    // raster order with unlimited credit; start pulses while busy must be ignored
    res_consumed = 1'b1;
    begin_pass(1'b1);
    for (int n = 0; n < 60 && ph != 0; n++) begin
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    chk("A_idle", ph, 0);
    chk("A_windows", nwin, TOT);
    chk("A_done", ndone, 1);
    // weight load with wld_ready toggling
    wld_ready = 1'b1;
    begin_pass(1'b0);
    for (int n = 0; n < 200 && ph != 0; n++) begin
      wld_ready = ~wld_ready;
      res_consumed = 1'($urandom_range(0, 1));
      tick();
    end
    chk("B_idle", ph, 0);
    chk("B_handshakes", nhs, NW);
    chk("B_windows", nwin, TOT);
    chk("B_done", ndone, 1);
    // credit stall: two issues, then one more per consumed result
    res_consumed = 1'b0;
    begin_pass(1'b1);
    repeat (15) tick();
    chk("C_stall", nwin, CR);
    res_consumed = 1'b1;
    tick();
    res_consumed = 1'b0;
    repeat (10) tick();
    chk("C_one_more", nwin, CR + 1);
    res_consumed = 1'b1;
    run_to_idle("C_finish", 100);
    chk("C_windows", nwin, TOT);
    // random handshakes and consumption, covering simultaneous issue and consume
    for (int p = 0; p < 4; p++) begin
      begin_pass(1'($urandom_range(0, 1)));
      for (int n = 0; n < 300 && ph != 0; n++) begin
        wld_ready = 1'($urandom_range(0, 1));
        res_consumed = 1'($urandom_range(0, 3) != 0);
        tick();
      end
      chk("D_idle", ph, 0);
      chk("D_windows", nwin, TOT);
      chk("D_done", ndone, 1);
    end
    // abort at window (1,1), then restart from (0,0)
    res_consumed = 1'b1;
    begin_pass(1'b1);
    begin
      int n = 0;
      while (!(window_valid && win_row == 1 && win_col == 1) && n < 50) begin
        tick();
        n++;
      end
      chk("E_reach_1_1", n < 50, 1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("E_busy", busy, 0);
    chk("E_no_done", ndone, 0);
    begin_pass(1'b1);
    chk("E_restart_valid", window_valid, 1);
    chk("E_restart_row", win_row, 0);
    chk("E_restart_col", win_col, 0);
    run_to_idle("E_finish", 100);
    // start while loading is ignored; asynchronous reset mid-load
    wld_ready = 1'b1;
    begin_pass(1'b0);
    start = 1'b1; skip_wload = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("F_in_load", wld_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("F_rst_wld_valid", wld_valid, 0);
    chk("F_rst_busy", busy, 0);
    chk("F_rst_addr", wld_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    check_outs();
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv2_sched.md
CONV2_SCHED -- requirements
Module: conv2_sched

Interface
REQ-001 SHALL have parameter IMG_H, default 8: input feature-map height.
REQ-002 SHALL have parameter IMG_W, default 8: input feature-map width.
REQ-003 SHALL have parameter K, default 3: kernel size; stride is 1 and there is no padding.
REQ-004 SHALL have parameters N_IN (16) and OUT_CH (32), giving NUM_W = OUT_CH*N_IN*K*K weight words.
REQ-005 SHALL have parameter CREDITS, default 4: number of results allowed to be outstanding downstream.
REQ-006 SHALL have the following ports, clock and reset first; reset rst is asynchronous and active-high, and the clock is clk:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle pulse that begins a layer pass
- skip_wload  in  1  sampled with start; 1 skips the weight-load phase
- abort  in  1  synchronous cancel of the current pass
- wld_valid  out  1  weight-load request strobe
- wld_addr  out  $clog2(NUM_W)  weight word index
- wld_ready  in  1  weight word accepted
- win_row  out  $clog2(IMG_H)  top-left row of the issued window
- win_col  out  $clog2(IMG_W)  top-left column of the issued window
- window_valid  out  1  window issue strobe to the datapath
- res_consumed  in  1  downstream has consumed one result
- busy  out  1  high when the FSM is not in IDLE
- done  out  1  single-cycle end-of-pass pulse

Function
REQ-007 SHALL implement the FSM states IDLE, LOAD, RUN, DRAIN and DONE.
REQ-008 SHALL, in IDLE, move to LOAD on start when skip_wload=0, or to RUN on start when skip_wload=1.
REQ-009 SHALL ignore start in every state other than IDLE.
REQ-010 SHALL, in LOAD, hold wld_valid=1 and advance wld_addr by 1 on each cycle where wld_valid and wld_ready are both high.
REQ-011 SHALL move from LOAD to RUN in the cycle after the handshake with wld_addr=NUM_W-1, and SHALL hold wld_valid=0 in that cycle.
REQ-012 SHALL define OUT_H=IMG_H-K+1 and OUT_W=IMG_W-K+1; windows are issued in raster order with col fastest, starting at (0,0).
REQ-013 SHALL assert window_valid in RUN only when the credit count is greater than 0, and SHALL then present the current (win_row, win_col) in the same cycle.
REQ-014 SHALL advance col on each issue, wrapping to 0 and incrementing row when col=OUT_W-1.
REQ-015 SHALL, after issuing window (OUT_H-1, OUT_W-1), move to DRAIN with window_valid=0 from the next cycle.
REQ-016 SHALL keep a credit counter of width $clog2(CREDITS+1), initialised to CREDITS on entry to RUN: minus 1 per issue, plus 1 per res_consumed, net 0 when both occur in the same cycle.
REQ-017 SHALL never let the credit counter exceed CREDITS; a res_consumed at full credit is ignored.
REQ-018 SHALL move from DRAIN to DONE when the credit count equals CREDITS.
REQ-019 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE.
REQ-020 SHALL, on abort in any non-IDLE state, return to IDLE next cycle with all strobes 0, counters cleared and done not pulsed; abort has priority over every other transition.
REQ-021 SHALL drive win_row/win_col to 0 outside RUN and wld_addr to 0 outside LOAD.
REQ-022 SHALL drive every output from a register.

Reset
REQ-023 SHALL, while rst=1, force the state to IDLE; busy, done, wld_valid and window_valid to 0; wld_addr, win_row and win_col to 0; and credits to CREDITS.
REQ-024 SHALL, when rst is asserted mid-pass, drop all strobes immediately (asynchronously); the pass is not resumed after rst deasserts.

Verification
REQ-025 SHALL check: IMG_H=IMG_W=5, K=3, skip_wload=1, res_consumed tied 1 -> 9 windows issued in raster order (0,0)..(2,2), then DRAIN, and done pulses once.
REQ-026 SHALL check: N_IN=1, OUT_CH=2, K=3, wld_ready toggling 1/0 -> wld_addr steps 0..17 only on handshakes, and RUN starts after addr 17.
REQ-027 SHALL check: CREDITS=2, res_consumed held 0 -> exactly 2 window_valid pulses, then stall; one res_consumed pulse -> exactly one more issue.
REQ-028 SHALL check: issue and res_consumed in the same cycle -> credit count unchanged.
REQ-029 SHALL check: abort during RUN at window (1,1) -> IDLE next cycle, no done pulse, and a following start restarts at (0,0).
REQ-030 SHALL check: start while busy -> no effect; rst mid-LOAD -> wld_valid=0 in the same cycle and busy=0.
